// File: rtl/iter_muldiv_rv32m.sv
// iter_muldiv_rv32m: iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide)
// with valid/ready handshake, flush, and divide-by-zero / signed-overflow early-out.
module iter_muldiv_rv32m #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [2*DATA_W-1:0] acc, acc_nxt, prod;
    logic [DATA_W-1:0]   opnd;
    logic                a_sgn, b_sgn, sa, sb, is_div, div_zero, div_ovf, fast, accept;
    logic [DATA_W-1:0]   abs_a, abs_b, fast_res, sel, fix_res;
    logic [DATA_W:0]     msum, rs;
    logic [DATA_W+1:0]   trial;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        a_sgn    = op[2] ? ~op[0] : (op[1] ^ op[0]);
        b_sgn    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        sa       = a_sgn & a[DATA_W-1];
        sb       = b_sgn & b[DATA_W-1];
        abs_a    = sa ? -a : a;
        abs_b    = sb ? -b : b;
        is_div   = op[2];
        div_zero = is_div && b == '0;
        div_ovf  = is_div && !op[0] && a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1;
        fast     = div_zero || div_ovf;
        fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
        accept   = in_valid && in_ready && !flush;
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        msum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        rs      = acc[2*DATA_W-1:DATA_W-1];
        trial   = {1'b0, rs} - {2'b0, opnd};
        acc_nxt = op_q[2] ? {trial[DATA_W+1] ? rs[DATA_W-1:0] : trial[DATA_W-1:0], acc[DATA_W-2:0], ~trial[DATA_W+1]}
                          : {msum, acc[DATA_W-1:1]};
        prod    = neg_q ? -acc : acc;
        sel     = op_q[1] ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
        fix_res = op_q[2] ? (neg_q ? -sel : sel)
                          : (op_q == 3'b000 ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
            CALC: state_nxt = flush ? IDLE : (cnt == CNT_W'(DATA_W - 1) ? FIX : CALC);
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = (flush || out_ready) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op;
                neg_q <= (is_div && op[1]) ? sa : (sa ^ sb);
                cnt   <= '0;
                acc   <= {{DATA_W{1'b0}}, is_div ? abs_a : abs_b};
                opnd  <= is_div ? abs_b : abs_a;
                if (fast)
                    result <= fast_res;
            end
            if (state == CALC) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX && !flush)
                result <= fix_res;
        end
    end
endmodule
